// File: rtl/cpu_ifetch_if.sv
// Instruction memory request/response bus between the fetch stage and the I-side memory.
// In-order responses; a request is accepted when imem_req and imem_gnt are both high.
interface cpu_ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/cpu_ifetch.sv
// Falcon P1 fetch stage: sequential PC generation, in-order imem requests, a small
// reservation queue feeding decode, and redirect with discard of wrong-path responses.
module cpu_ifetch #(
    parameter logic [31:0] RESET_PC    = 32'hFFFF_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                p2_bubble,
    input  logic                p3_jump_taken,
    input  logic [31:0]         p3_jump_target,
    cpu_ifetch_if.master        imem,
    output logic [31:0]         p2_instr,
    output logic [31:0]         p2_pc,
    output logic                p2_instr_valid
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]          pc_q, pc_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        unfilled_q, unfilled_d;
    logic [CW-1:0]        drop_q, drop_d;

    logic [31:0]          ent_pc_q     [QUEUE_DEPTH];
    logic [31:0]          ent_instr_q  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] ent_filled_q;

    logic                 redirect;
    logic [CW-1:0]        occupancy;
    logic [CW-1:0]        pending;
    logic                 req;
    logic                 issue;
    logic                 head_valid;
    logic                 pop;
    logic                 fill;
    logic                 drop_rsp;
    logic [PW-1:0]        fill_idx;

    assign redirect   = p3_jump_taken && !stall;
    // Entries in the queue plus responses still owed to a discarded path share the budget.
    assign occupancy  = count_q + drop_q;
    assign req        = !reset && !redirect && (occupancy < DEPTH_C);
    assign issue      = req && imem.imem_gnt;
    assign head_valid = (count_q != '0) && ent_filled_q[head_q];
    assign pop        = head_valid && !stall && !p2_bubble && !redirect;
    assign drop_rsp   = imem.imem_rvalid && (drop_q != '0);
    assign fill       = imem.imem_rvalid && (drop_q == '0) && (unfilled_q != '0);
    // Unfilled entries are always the youngest ones, so the oldest sits unfilled_q behind the tail.
    assign fill_idx   = tail_q - unfilled_q[PW-1:0];

    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        drop_d     = drop_q;
        pending    = '0;
        if (redirect) begin
            pc_d       = p3_jump_target & 32'hFFFF_FFFC;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            unfilled_d = '0;
            pending    = unfilled_q + drop_q;
            if (imem.imem_rvalid && (pending != '0)) begin
                pending = pending - CNT_ONE;
            end
            drop_d = pending;
        end else begin
            if (issue) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (drop_rsp) begin
                drop_d = drop_q - CNT_ONE;
            end
            count_d    = count_q + CW'(issue) - CW'(pop);
            unfilled_d = unfilled_q + CW'(issue) - CW'(fill);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            unfilled_q   <= '0;
            drop_q       <= '0;
            ent_filled_q <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                ent_pc_q[i]    <= '0;
                ent_instr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
            drop_q     <= drop_d;
            if (redirect) begin
                ent_filled_q <= '0;
            end else begin
                if (issue) begin
                    ent_pc_q[tail_q]     <= pc_q;
                    ent_filled_q[tail_q] <= 1'b0;
                end
                if (fill) begin
                    ent_instr_q[fill_idx]  <= imem.imem_rdata;
                    ent_filled_q[fill_idx] <= 1'b1;
                end
            end
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign p2_instr_valid = !reset && head_valid;
    assign p2_instr       = reset ? 32'h0 : ent_instr_q[head_q];
    assign p2_pc          = reset ? 32'h0 : ent_pc_q[head_q];

    // A response with nothing waiting for it and nothing owed means the memory broke ordering.
    a_no_orphan_rsp: assert property (@(posedge clock) disable iff (reset)
        !(imem.imem_rvalid && (drop_q == '0) && (unfilled_q == '0)));
endmodule
